// File: rtl/fpu_pkg.sv
// fpu_pkg: definitions shared between the fpu and its operand loader.
//   fpu_status_e   : one-hot conversion / arithmetic status code
//   loader_state_e : operand loader FSM states
//   bias constants : IEEE-754 binary32 vs. fpu native 1/6/25 format
//   merge_status   : combine two per-operand statuses into one pair status
package fpu_pkg;

  typedef enum logic [3:0] {
    ST_EXACT     = 4'b0001,
    ST_INEXACT   = 4'b0010,
    ST_OVERFLOW  = 4'b0100,
    ST_UNDERFLOW = 4'b1000
  } fpu_status_e;

  localparam int IEEE_BIAS   = 127;
  localparam int FPU_BIAS    = 31;
  localparam int EXP_OFFSET  = IEEE_BIAS - FPU_BIAS;  // 96
  localparam int FPU_EXP_MAX = 62;                    // 63 is reserved by the fpu

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_CONV_A,
    LD_CONV_B,
    LD_HOLD
  } loader_state_e;

  // Overflow dominates underflow, which dominates exact.
  function automatic logic [3:0] merge_status(input logic [3:0] st_a, input logic [3:0] st_b);
    if (st_a == ST_OVERFLOW || st_b == ST_OVERFLOW) begin
      return ST_OVERFLOW;
    end
    if (st_a == ST_UNDERFLOW || st_b == ST_UNDERFLOW) begin
      return ST_UNDERFLOW;
    end
    return ST_EXACT;
  endfunction

endpackage

// File: rtl/fp32_to_fpu_fmt.sv
// fp32_to_fpu_fmt: combinational IEEE-754 binary32 -> fpu 1/6/25 conversion.
// Ports:
//   fp32    in  32  binary32 operand
//   fpu_op  out 32  {sign, 6-bit exponent (bias 31), 23-bit fraction, 2'b00}, or 0
//   status  out 4   ST_EXACT / ST_OVERFLOW / ST_UNDERFLOW (one-hot)
// Values outside the fpu's normal exponent range are flushed to zero and
// flagged; in-range values convert losslessly.
module fp32_to_fpu_fmt
  import fpu_pkg::*;
(
  input  logic [31:0] fp32,
  output logic [31:0] fpu_op,
  output logic [3:0]  status
);

  logic        sign;
  logic [7:0]  exp_ieee;
  logic [22:0] frac;
  logic [5:0]  exp_fpu;

  assign sign     = fp32[31];
  assign exp_ieee = fp32[30:23];
  assign frac     = fp32[22:0];

  // Rebias in 8 bits; only the in-range branch below uses the truncated result.
  assign exp_fpu = 6'(exp_ieee - 8'(EXP_OFFSET));

  // NOTE: every output gets a default before the if-chain so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    fpu_op = '0;
    status = ST_EXACT;
    if (exp_ieee == 8'd0) begin
      status = (frac != '0) ? ST_UNDERFLOW : ST_EXACT;
    end else if (exp_ieee == 8'hFF) begin
      status = ST_OVERFLOW;
    end else if (exp_ieee <= 8'(EXP_OFFSET)) begin
      status = ST_UNDERFLOW;
    end else if (exp_ieee > 8'(EXP_OFFSET + FPU_EXP_MAX)) begin
      status = ST_OVERFLOW;
    end else begin
      fpu_op = {sign, exp_fpu, frac, 2'b00};
    end
  end

endmodule

// File: rtl/fpu_operand_loader.sv
// fpu_operand_loader: accepts binary32 operand pairs over valid/ready,
// converts them one at a time through a shared converter, then holds the
// converted operands stable with op_valid high for HOLD_CYCLES cycles.
// Ports:
//   clock100KHz  in  1   clock, rising edge
//   reset        in  1   synchronous, active-high
//   in_valid     in  1   upstream pair valid
//   in_ready     out 1   high only in IDLE and not in reset
//   in_a, in_b   in  32  binary32 operands
//   op_A_in      out 32  converted operand A
//   op_B_in      out 32  converted operand B
//   op_valid     out 1   high during the hold window
//   done         out 1   pulse on the last hold cycle
//   conv_status  out 4   merged one-hot status of the pair
module fpu_operand_loader
  import fpu_pkg::*;
#(
  parameter int HOLD_CYCLES = 48  // 1..255
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] op_A_in,
  output logic [31:0] op_B_in,
  output logic        op_valid,
  output logic        done,
  output logic [3:0]  conv_status
);

  loader_state_e state, state_next;

  logic [31:0] a_reg, b_reg;
  logic [3:0]  status_a;
  logic [7:0]  hold_cnt;

  logic [31:0] conv_in, conv_out;
  logic [3:0]  conv_st;

  // One converter serves both operands: A in CONV_A, B in CONV_B.
  assign conv_in = (state == LD_CONV_B) ? b_reg : a_reg;

  fp32_to_fpu_fmt u_conv (
    .fp32   (conv_in),
    .fpu_op (conv_out),
    .status (conv_st)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state <= LD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are forced low while reset is asserted, even before the first
  // reset edge has pulled the state back to IDLE.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    op_valid   = 1'b0;
    done       = 1'b0;
    case (state)
      LD_IDLE: begin
        in_ready = !reset;
        if (in_valid) begin
          state_next = LD_CONV_A;
        end
      end
      LD_CONV_A: state_next = LD_CONV_B;
      LD_CONV_B: state_next = LD_HOLD;
      LD_HOLD: begin
        op_valid = !reset;
        if (hold_cnt == 8'd0) begin
          done       = !reset;
          state_next = LD_IDLE;
        end
      end
      default: state_next = LD_IDLE;
    endcase
  end

  // Operand regs are cleared too so a reset leaves the datapath in a
  // known state for the outputs that expose it.
  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      a_reg       <= '0;
      b_reg       <= '0;
      status_a    <= '0;
      op_A_in     <= '0;
      op_B_in     <= '0;
      conv_status <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
          end
        end
        LD_CONV_A: begin
          op_A_in  <= conv_out;
          status_a <= conv_st;
        end
        LD_CONV_B: begin
          op_B_in     <= conv_out;
          conv_status <= merge_status(status_a, conv_st);
          hold_cnt    <= 8'(HOLD_CYCLES - 1);
        end
        LD_HOLD: begin
          if (hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Self-checking bench for fpu_operand_loader: directed vectors, exponent
// boundaries, random pairs, continuous-valid back-to-back and mid-hold reset,
// all checked against a value-level reference model.
module tb_fpu_operand_loader;

  localparam int HOLD = 48;

  logic        clock100KHz = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] op_A_in, op_B_in;
  logic        op_valid;
  logic        done;
  logic [3:0]  conv_status;

  int checks   = 0;
  int failures = 0;

  fpu_operand_loader #(.HOLD_CYCLES(HOLD)) dut (
    .clock100KHz (clock100KHz),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .op_A_in     (op_A_in),
    .op_B_in     (op_B_in),
    .op_valid    (op_valid),
    .done        (done),
    .conv_status (conv_status)
  );

  always #5 clock100KHz = ~clock100KHz;

  // Drive and sample 2 time units after each rising edge.
  task automatic step();
    @(posedge clock100KHz);
    #2;
  endtask

  // Reference conversion: unbias the IEEE exponent, rebias to 31, and
  // classify by where the real exponent lands.
  function automatic logic [31:0] ref_conv(input logic [31:0] x, output logic [3:0] st);
    int e, fe;
    logic [5:0] fe6;
    e  = int'(x[30:23]);
    fe = (e - 127) + 31;
    fe6 = fe[5:0];
    if (e == 0) begin
      st = (x[22:0] == 23'd0) ? 4'b0001 : 4'b1000;
      return 32'd0;
    end
    if (e == 255) begin st = 4'b0100; return 32'd0; end
    if (fe <= 0)  begin st = 4'b1000; return 32'd0; end
    if (fe >= 63) begin st = 4'b0100; return 32'd0; end
    st = 4'b0001;
    return {x[31], fe6, x[22:0], 2'b00};
  endfunction

  function automatic logic [3:0] ref_merge(input logic [3:0] a, input logic [3:0] b);
    if (a == 4'b0100 || b == 4'b0100) return 4'b0100;
    if (a == 4'b1000 || b == 4'b1000) return 4'b1000;
    return 4'b0001;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    f = 23'($urandom);
    case ($urandom_range(0, 5))
      0: begin e = 8'd0; if ($urandom_range(0, 1) == 0) f = 23'd0; end
      1: e = 8'($urandom_range(1, 96));
      2, 3: e = 8'($urandom_range(97, 158));
      4: e = 8'($urandom_range(159, 254));
      default: e = 8'd255;
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Offer one pair, then follow it through CONV_A, CONV_B, the full hold
  // window and the return to IDLE.
  task automatic run_pair(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] ea, eb;
    logic [3:0]  sa, sb, es;
    int waited;
    ea = ref_conv(a, sa);
    eb = ref_conv(b, sb);
    es = ref_merge(sa, sb);
    waited = 0;
    while (in_ready !== 1'b1 && waited < 100) begin step(); waited++; end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_timeout in_ready=%b expected=1", tag, in_ready);
      return;
    end
    in_a = a; in_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || op_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s conv_a in_ready=%b op_valid=%b expected=0/0", tag, in_ready, op_valid);
    end
    step();
    checks++;
    if (op_valid !== 1'b0 || op_A_in !== ea) begin
      failures++;
      $display("FAIL %s conv_b op_valid=%b op_A_in=%h expected=0/%h", tag, op_valid, op_A_in, ea);
    end
    step();
    checks++;
    if (op_A_in !== ea || op_B_in !== eb || conv_status !== es) begin
      failures++;
      $display("FAIL %s values A=%h B=%h st=%b expected=%h %h %b",
               tag, op_A_in, op_B_in, conv_status, ea, eb, es);
    end
    for (int i = 0; i < HOLD; i++) begin
      checks++;
      if (op_valid !== 1'b1 || in_ready !== 1'b0 || done !== (i == HOLD - 1)) begin
        failures++;
        $display("FAIL %s hold[%0d] op_valid=%b in_ready=%b done=%b expected=1/0/%b",
                 tag, i, op_valid, in_ready, done, (i == HOLD - 1));
      end
      step();
    end
    checks++;
    if (op_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1 ||
        op_A_in !== ea || op_B_in !== eb || conv_status !== es) begin
      failures++;
      $display("FAIL %s after_hold op_valid=%b done=%b in_ready=%b A=%h B=%h st=%b expected=0/0/1 %h %h %b",
               tag, op_valid, done, in_ready, op_A_in, op_B_in, conv_status, ea, eb, es);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    step();
    step();
    checks++;
    if (in_ready !== 1'b0 || op_valid !== 1'b0 || done !== 1'b0 ||
        op_A_in !== 32'd0 || op_B_in !== 32'd0 || conv_status !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state in_ready=%b op_valid=%b done=%b A=%h B=%h st=%b expected all 0",
               in_ready, op_valid, done, op_A_in, op_B_in, conv_status);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release in_ready=%b expected=1", in_ready);
    end
  endtask

  task automatic test_spec_vectors();
    run_pair(32'h3F800000, 32'h40000000, "one_two");
    run_pair(32'h3FC00000, 32'hC0000000, "neg_two");
    run_pair(32'h50000000, 32'h3F800000, "overflow_a");
    run_pair(32'h30000000, 32'h00000001, "underflow");
    run_pair(32'h00000000, 32'h3F800000, "zero_a");
  endtask

  task automatic test_boundaries();
    logic [7:0] exps [9];
    exps = '{8'd0, 8'd1, 8'd96, 8'd97, 8'd127, 8'd158, 8'd159, 8'd254, 8'd255};
    for (int i = 0; i < 9; i++) begin
      run_pair({1'($urandom), exps[i], 23'($urandom)}, 32'h40000000, "boundary");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      run_pair(rand_fp(), rand_fp(), "random");
    end
  endtask

  // in_valid stays high; a new pair is presented right after each accept.
  task automatic test_back_to_back();
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    int acc_idx[$];
    int acc_cyc[$];
    int idx, windows, run_len, cyc, k, c;
    logic prev_v, accept;
    logic [31:0] ea, eb;
    logic [3:0]  sa, sb;
    for (int i = 0; i < 4; i++) begin pa[i] = rand_fp(); pb[i] = rand_fp(); end
    idx = 0; windows = 0; run_len = 0; cyc = 0; prev_v = 1'b0;
    in_a = pa[0]; in_b = pb[0]; in_valid = 1'b1;
    while (windows < 4 && cyc < 1000) begin
      accept = (in_ready === 1'b1) && in_valid;
      checks++;
      if (in_ready === 1'b1 && op_valid === 1'b1) begin
        failures++;
        $display("FAIL b2b ready_during_hold cycle=%0d in_ready=%b expected=0", cyc, in_ready);
      end
      if (op_valid === 1'b1 && prev_v !== 1'b1) begin
        checks++;
        if (acc_idx.size() == 0) begin
          failures++;
          $display("FAIL b2b window_without_accept cycle=%0d op_valid=%b expected=0", cyc, op_valid);
        end else begin
          k = acc_idx.pop_front();
          c = acc_cyc.pop_front();
          ea = ref_conv(pa[k], sa);
          eb = ref_conv(pb[k], sb);
          if (op_A_in !== ea || op_B_in !== eb || conv_status !== ref_merge(sa, sb) || cyc - c != 3) begin
            failures++;
            $display("FAIL b2b pair%0d A=%h B=%h st=%b latency=%0d expected=%h %h %b 3",
                     k, op_A_in, op_B_in, conv_status, cyc - c, ea, eb, ref_merge(sa, sb));
          end
        end
      end
      if (op_valid === 1'b1) run_len++;
      if (done === 1'b1) begin
        windows++;
        checks++;
        if (run_len != HOLD) begin
          failures++;
          $display("FAIL b2b hold_length got=%0d expected=%0d", run_len, HOLD);
        end
        run_len = 0;
      end
      prev_v = op_valid;
      if (accept) begin acc_idx.push_back(idx); acc_cyc.push_back(cyc); end
      step();
      cyc++;
      if (accept) begin
        idx++;
        if (idx < 4) begin in_a = pa[idx]; in_b = pb[idx]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (windows != 4 || idx != 4 || acc_idx.size() != 0) begin
      failures++;
      $display("FAIL b2b totals windows=%0d accepts=%0d pending=%0d expected=4 4 0",
               windows, idx, acc_idx.size());
    end
    step();
  endtask

  task automatic test_reset_mid_hold();
    int waited, done_seen;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 100) begin step(); waited++; end
    in_a = 32'h3F800000; in_b = 32'h40000000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();                              // hold cycle 1
    for (int i = 0; i < 9; i++) step();  // hold cycle 10
    checks++;
    if (op_valid !== 1'b1 || op_A_in !== 32'h3E000000) begin
      failures++;
      $display("FAIL rst_hold pre op_valid=%b A=%h expected=1 3e000000", op_valid, op_A_in);
    end
    reset = 1'b1;
    step();
    checks++;
    if (op_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 ||
        op_A_in !== 32'd0 || op_B_in !== 32'd0 || conv_status !== 4'b0000) begin
      failures++;
      $display("FAIL rst_hold post op_valid=%b done=%b in_ready=%b A=%h B=%h st=%b expected all 0",
               op_valid, done, in_ready, op_A_in, op_B_in, conv_status);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_hold release in_ready=%b expected=1", in_ready);
    end
    done_seen = 0;
    for (int i = 0; i < HOLD + 10; i++) begin
      step();
      if (done === 1'b1 || op_valid === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL rst_hold no_done cycles_with_done_or_valid=%0d expected=0", done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_boundaries();
    test_random();
    test_back_to_back();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
